bin_a_bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter that feeds the four digit inputs of the 7-segment display stage.
//  - Converts an unsigned binary value (max 9999) into four BCD digits using iterative shift-add-3
//    (double dabble), one bit per clock.
//  - Holds the last result stable on d0..d3 until the next conversion completes, so the display

---
 rtl/bin_a_bcd_seq_pkg.sv | 16 +
 rtl/bin_a_bcd_seq_add3.sv | 10 +
 rtl/bin_a_bcd_seq.sv | 97 +++++++++
 tb/tb_bin_a_bcd_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bin_a_bcd_seq_pkg.sv
// Shared constants for the binary-to-BCD display path.
// State encoding, digit geometry and the four-digit ceiling.
package bin_a_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam int BCD_MAX = 9999;
  localparam int DIG_W   = 4;
  localparam int N_DIG   = 4;
  localparam int BCD_W   = DIG_W * N_DIG;

endpackage

// File: rtl/bin_a_bcd_seq_add3.sv
// Per-nibble double-dabble corrector.
// Adds 3 to a BCD digit of 5 or more ahead of the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_a_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock.
// Digits hold the last result until the next conversion ends.
module bin_a_bcd_seq
  import bin_a_bcd_seq_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = BCD_MAX
) (
  input  logic             clk_g,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       d0,
  output logic [3:0]       d1,
  output logic [3:0]       d2,
  output logic [3:0]       d3
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] MAXV = (WIDTH + 1)'(MAX_VAL);

  state_t state, state_nx;

  logic [WIDTH-1:0] sh;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_c;
  logic [CW-1:0]    cnt;
  logic             big;

  for (genvar i = 0; i < N_DIG; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc[i*DIG_W +: DIG_W]),
      .dout (acc_c[i*DIG_W +: DIG_W])
    );
  end

  always_ff @(posedge clk_g) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk_g) begin
    if (rst) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      big  <= 1'b0;
      done <= 1'b0;
      ovf  <= 1'b0;
      d0   <= '0;
      d1   <= '0;
      d2   <= '0;
      d3   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sh  <= bin;
            acc <= '0;
            cnt <= '0;
            big <= {1'b0, bin} > MAXV;
          end
        end
        SHIFT: begin
          {acc, sh} <= {acc_c[BCD_W-2:0], sh, 1'b0};
          cnt       <= cnt + 1'b1;
        end
        FIN: begin
          done <= 1'b1;
          ovf  <= big;
          // Saturate so an out-of-range value never shows as a wrapped number
          if (big) {d3, d2, d1, d0} <= {N_DIG{4'd9}};
          else     {d3, d2, d1, d0} <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_a_bcd_seq.sv
// Scoreboard bench for bin_a_bcd_seq.
// Stimulus pushes expected digits; a negedge monitor checks them.
module tb_bin_a_bcd_seq;

  logic        clk_g = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin   = '0;
  logic        busy, done, ovf;
  logic [3:0]  d0, d1, d2, d3;

  typedef struct {
    logic [16:0] exp;
    int          s;
  } item_t;

  item_t       q[$];
  int          cyc     = 0;
  logic        rst_q   = 1'b0;
  logic        fin_req = 1'b0;
  int          n_chk   = 0;
  int          n_fail  = 0;
  logic [16:0] held    = '0;

  bin_a_bcd_seq dut (
    .clk_g (clk_g),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3)
  );

  always #5 clk_g = ~clk_g;

  always @(posedge clk_g) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic logic [16:0] model(input int v);
    int   s;
    logic o;
    o = (v > 9999);
    s = o ? 9999 : v;
    return {o, 4'((s / 1000) % 10), 4'((s / 100) % 10),
            4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h",
               nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk_g) begin
    logic [16:0] got;
    got = {ovf, d3, d2, d1, d0};
    if (cyc >= 1) begin
      if (rst_q) begin
        check("reset_out", {13'd0, busy, done, got}, 32'd0);
        held = '0;
      end else if (q.size() > 0 && cyc < q[0].s + 15) begin
        check("busy_conv", {30'd0, busy, done}, 32'd2);
        check("hold_conv", {15'd0, got}, {15'd0, held});
      end else if (q.size() > 0 && cyc == q[0].s + 15) begin
        check("done_fin", {30'd0, busy, done}, 32'd1);
        check("result", {15'd0, got}, {15'd0, q[0].exp});
        held = q[0].exp;
        void'(q.pop_front());
      end else begin
        check("idle", {30'd0, busy, done}, 32'd0);
        check("hold_idle", {15'd0, got}, {15'd0, held});
      end
      if (fin_req) begin
        check("drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
      end
    end
  end

  task automatic issue(input logic [13:0] v);
    bin   = v;
    start = 1'b1;
    @(posedge clk_g);
    #1;
    q.push_back(item_t'{model(int'(v)), cyc});
    for (int i = 0; i < 15; i++) begin
      if (i == 2) begin
        start = 1'b1;
        bin   = 14'd1111;
      end else begin
        start = (i == 14) ? 1'b1 : 1'($urandom);
        bin   = 14'($urandom);
      end
      @(posedge clk_g);
      #1;
    end
  endtask

  task automatic gap(input int n);
    start = 1'b0;
    bin   = 14'($urandom);
    repeat (n) begin
      @(posedge clk_g);
      #1;
    end
  endtask

  initial begin
    logic [13:0] edge_v [12];
    edge_v = '{14'd9998, 14'd9999, 14'd10000, 14'd10001, 14'd16383,
               14'd1, 14'd9, 14'd10, 14'd99, 14'd100, 14'd999, 14'd1000};
    repeat (2) @(posedge clk_g);
    #1 rst = 1'b0;
    gap(1);
    issue(14'd1234);
    gap(2);
    issue(14'd0);
    issue(14'd9999);
    issue(14'd12000);
    issue(14'd42);
    issue(14'd5678);
    bin   = 14'd4321;
    start = 1'b1;
    @(posedge clk_g);
    #1;
    q.push_back(item_t'{model(4321), cyc});
    start = 1'b0;
    repeat (6) @(posedge clk_g);
    #1 rst = 1'b1;
    @(posedge clk_g);
    #1;
    rst = 1'b0;
    q.delete();
    gap(2);
    issue(14'd1);
    foreach (edge_v[i]) issue(edge_v[i]);
    repeat (2500) begin
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) issue(14'($urandom_range(0, 9999)));
      else                           issue(14'($urandom));
    end
    gap(3);
    fin_req = 1'b1;
  end

endmodule
